sprite_renderer: RTL



---
 rtl/sprite_renderer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sprite_renderer.sv
// sprite_renderer: snapshots sprite records once per frame and maps each
// pixel coordinate to a colour through a fixed 2-cycle pipeline.
// Optional build macro SPRITE_RENDERER_DEBUG_EN: per-element debug colours
// and the debug_hit_o port.

// Sprite record: exclusive right/bottom edges
typedef struct packed {
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [9:0] right;
  logic [9:0] bottom;
} sprite_t;

module sprite_renderer #(
  parameter int unsigned X_POS_W              = 10,
  parameter int unsigned Y_POS_W              = 10,
  parameter int unsigned SCREEN_H_RES         = 640,
  parameter int unsigned SCREEN_V_RES         = 480,
  parameter int unsigned SCREEN_BORDER        = 10,
  parameter int unsigned SEPARATOR_WIDTH      = 6,
  parameter int unsigned SEPARATOR_DOT_HEIGHT = 18,
  parameter int unsigned RGB_W                = 12,
  parameter logic [RGB_W-1:0] FG_COLOR        = 12'hFFF,
  parameter logic [RGB_W-1:0] BG_COLOR        = 12'h000
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               sprite_upd_i,
  input  sprite_t            player_i,
  input  sprite_t            enemy_i,
  input  sprite_t            ball_i,
  input  logic               frame_start_i,
  input  logic               line_start_i,
  input  logic               pix_valid_i,
  input  logic [X_POS_W-1:0] x_i,
  input  logic [Y_POS_W-1:0] y_i,
  output logic [RGB_W-1:0]   rgb_o,
  output logic               rgb_valid_o
`ifdef SPRITE_RENDERER_DEBUG_EN
  ,
  output logic [4:0]         debug_hit_o
`endif
);

  localparam int unsigned DOT_CNT_W  = (SEPARATOR_DOT_HEIGHT > 1) ? $clog2(SEPARATOR_DOT_HEIGHT) : 1;
  localparam int unsigned SEP_LO     = SCREEN_H_RES / 2 - SEPARATOR_WIDTH / 2;
  localparam int unsigned SEP_HI     = SCREEN_H_RES / 2 + SEPARATOR_WIDTH / 2;
  localparam int unsigned BORDER_BOT = SCREEN_V_RES - SCREEN_BORDER;

`ifdef SPRITE_RENDERER_DEBUG_EN
  localparam logic [RGB_W-1:0] DBG_BALL   = RGB_W'(12'hFF0);
  localparam logic [RGB_W-1:0] DBG_PLAYER = RGB_W'(12'h0F0);
  localparam logic [RGB_W-1:0] DBG_ENEMY  = RGB_W'(12'hF00);
  localparam logic [RGB_W-1:0] DBG_BORDER = RGB_W'(12'h00F);
  localparam logic [RGB_W-1:0] DBG_SEP    = RGB_W'(12'h888);
`endif

  sprite_t player_sh, enemy_sh, ball_sh;
  sprite_t player_act, enemy_act, ball_act;

  logic [DOT_CNT_W-1:0] dot_cnt;
  logic                 dot_on;

  logic s1_valid;
  logic s1_ball_hit, s1_player_hit, s1_enemy_hit, s1_border_hit, s1_sep_hit;

  logic [RGB_W-1:0] rgb_d;

  // Unsigned rectangle test; degenerate rectangles can never satisfy both bounds
  function automatic logic sprite_hit(input sprite_t s,
                                      input logic [X_POS_W-1:0] x,
                                      input logic [Y_POS_W-1:0] y);
    sprite_hit = (x >= X_POS_W'(s.x_pos)) && (x < X_POS_W'(s.right)) &&
                 (y >= Y_POS_W'(s.y_pos)) && (y < Y_POS_W'(s.bottom));
  endfunction

  // Shadow capture on update; active snapshot only at frame start (bypass when coincident)
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      player_sh  <= '0;
      enemy_sh   <= '0;
      ball_sh    <= '0;
      player_act <= '0;
      enemy_act  <= '0;
      ball_act   <= '0;
    end else begin
      if (sprite_upd_i) begin
        player_sh <= player_i;
        enemy_sh  <= enemy_i;
        ball_sh   <= ball_i;
      end
      if (frame_start_i) begin
        player_act <= sprite_upd_i ? player_i : player_sh;
        enemy_act  <= sprite_upd_i ? enemy_i  : enemy_sh;
        ball_act   <= sprite_upd_i ? ball_i   : ball_sh;
      end
    end
  end

  // Separator dot/gap row counter; frame start wins over line start
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      dot_cnt <= '0;
      dot_on  <= 1'b1;
    end else if (frame_start_i) begin
      dot_cnt <= '0;
      dot_on  <= 1'b1;
    end else if (line_start_i) begin
      if (dot_cnt == DOT_CNT_W'(SEPARATOR_DOT_HEIGHT - 1)) begin
        dot_cnt <= '0;
        dot_on  <= ~dot_on;
      end else begin
        dot_cnt <= dot_cnt + DOT_CNT_W'(1);
      end
    end
  end

  // Stage 1: registered hit compares
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s1_valid      <= 1'b0;
      s1_ball_hit   <= 1'b0;
      s1_player_hit <= 1'b0;
      s1_enemy_hit  <= 1'b0;
      s1_border_hit <= 1'b0;
      s1_sep_hit    <= 1'b0;
    end else begin
      s1_valid      <= pix_valid_i;
      s1_ball_hit   <= sprite_hit(ball_act, x_i, y_i);
      s1_player_hit <= sprite_hit(player_act, x_i, y_i);
      s1_enemy_hit  <= sprite_hit(enemy_act, x_i, y_i);
      s1_border_hit <= (y_i < Y_POS_W'(SCREEN_BORDER)) || (y_i >= Y_POS_W'(BORDER_BOT));
      s1_sep_hit    <= dot_on && (x_i >= X_POS_W'(SEP_LO)) && (x_i < X_POS_W'(SEP_HI));
    end
  end

  // Stage 2 colour select: ball > player > enemy > border > separator > background
  always_comb begin
    rgb_d = BG_COLOR;
    if (s1_valid) begin
`ifdef SPRITE_RENDERER_DEBUG_EN
      if (s1_ball_hit)        rgb_d = DBG_BALL;
      else if (s1_player_hit) rgb_d = DBG_PLAYER;
      else if (s1_enemy_hit)  rgb_d = DBG_ENEMY;
      else if (s1_border_hit) rgb_d = DBG_BORDER;
      else if (s1_sep_hit)    rgb_d = DBG_SEP;
`else
      if (s1_ball_hit || s1_player_hit || s1_enemy_hit || s1_border_hit || s1_sep_hit)
        rgb_d = FG_COLOR;
`endif
    end
  end

  // Stage 2: registered colour and valid
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rgb_o       <= BG_COLOR;
      rgb_valid_o <= 1'b0;
    end else begin
      rgb_o       <= rgb_d;
      rgb_valid_o <= s1_valid;
    end
  end

`ifdef SPRITE_RENDERER_DEBUG_EN
  // Stage 2: raw hit flags aligned with rgb_o, cleared for invalid pixels
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      debug_hit_o <= '0;
    end else begin
      debug_hit_o <= s1_valid ? {s1_ball_hit, s1_player_hit, s1_enemy_hit, s1_border_hit, s1_sep_hit}
                              : 5'b00000;
    end
  end
`endif

endmodule
